mux_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 multiplexer among four requesters. It samples four request lines and grants the mux to one requester at a time for a fixed burst of cycles. It drives the mux's `address0`/`address1` selects directly, plus a one-hot grant vector back to the requesters. It sits between the requesting blocks and the mux select inputs.

---
 rtl/mux_arbiter.sv | 111 +++++++++++
 tb/tb_mux_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Round-robin arbiter that grants a shared 4:1 mux to one of four requesters for fixed bursts.
// Optional macro MUXARB_EARLY_RELEASE_EN ends a burst as soon as the owner drops its request.
module mux_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic req2,
    input  logic req3,
    output logic address0,
    output logic address1,
    output logic grant0,
    output logic grant1,
    output logic grant2,
    output logic grant3,
    output logic busy
);

    localparam logic       IDLE  = 1'b0;
    localparam logic       GRANT = 1'b1;
    localparam logic [7:0] LOAD  = 8'(BURST_LEN - 1);

    logic       state;
    logic [1:0] last;
    logic [7:0] cnt;
    logic [3:0] grant;
    logic [1:0] addr;
    logic [3:0] req;
    logic       win_found;
    logic [1:0] win_idx;
    logic       owner_drop;
    logic       burst_end;

    assign req = {req3, req2, req1, req0};

    // Scan from last+1 upward with wrap; the previous owner is checked last.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic       found;
        logic [1:0] idx;
        logic [1:0] sel;
        found = 1'b0;
        sel   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = l + 2'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

`ifdef MUXARB_EARLY_RELEASE_EN
    assign owner_drop = !req[last];
`else
    assign owner_drop = 1'b0;
`endif

    always_comb begin
        {win_found, win_idx} = rr_pick(req, last);
        burst_end            = (cnt == 8'd0) || owner_drop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= 4'b0000;
            busy  <= 1'b0;
            addr  <= 2'd0;
            last  <= 2'd3;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state <= GRANT;
                        grant <= 4'b0001 << win_idx;
                        busy  <= 1'b1;
                        addr  <= win_idx;
                        last  <= win_idx;
                        cnt   <= LOAD;
                    end
                end
                GRANT: begin
                    if (burst_end) begin
                        if (win_found) begin
                            grant <= 4'b0001 << win_idx;
                            addr  <= win_idx;
                            last  <= win_idx;
                            cnt   <= LOAD;
                        end else begin
                            // Address is left alone so the mux select stays stable while idle.
                            state <= IDLE;
                            grant <= 4'b0000;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {grant3, grant2, grant1, grant0} = grant;
    assign {address1, address0}             = addr;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: a cycle model pushes expected outputs, checked after each edge.
module tb_mux_arbiter;

    localparam int BL = 4;

    logic clk = 1'b0;
    logic reset;
    logic req0, req1, req2, req3;
    logic address0, address1;
    logic grant0, grant1, grant2, grant3;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] expq[$];

    // Reference model state
    logic       m_busy;
    logic [1:0] m_owner;
    logic [1:0] m_addr;
    logic [1:0] m_last;
    int         m_used;

    mux_arbiter #(.BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .req2(req2), .req3(req3),
        .address0(address0), .address1(address1),
        .grant0(grant0), .grant1(grant1), .grant2(grant2), .grant3(grant3),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] observed();
        return {busy, grant3, grant2, grant1, grant0, address1, address0};
    endfunction

    function automatic logic [6:0] model_out();
        logic [3:0] g;
        g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        return {m_busy, g, m_addr};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got busy/grant/addr=%b, expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 2'd0;
        m_addr  = 2'd0;
        m_last  = 2'd3;
        m_used  = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic       ending;
        logic       found;
        logic [1:0] cand;
        ending = !m_busy || (m_used == BL);
`ifdef MUXARB_EARLY_RELEASE_EN
        if (m_busy && !r[m_owner]) ending = 1'b1;
`endif
        if (!ending) begin
            m_used++;
        end else begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                cand = 2'((int'(m_last) + k) % 4);
                if (!found && r[cand]) begin
                    found   = 1'b1;
                    m_owner = cand;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_addr = m_owner;
                m_last = m_owner;
                m_used = 1;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic [3:0] r, input string tag);
        {req3, req2, req1, req0} = r;
        model_edge(r);
        expq.push_back(model_out());
        @(posedge clk);
        #1;
        if (expq.size() == 0) chk({tag, "_noexp"}, observed(), 7'bx);
        else chk(tag, observed(), expq.pop_front());
    endtask

    task automatic async_reset(input logic [3:0] r_after, input string tag);
        #2 reset = 1'b1;
        #1 chk({tag, "_async"}, observed(), 7'b0);
        @(posedge clk);
        #1;
        chk({tag, "_held"}, observed(), 7'b0);
        {req3, req2, req1, req0} = r_after;
        reset = 1'b0;
        model_reset();
        expq.delete();
    endtask

    initial begin
        reset = 1'b1;
        {req3, req2, req1, req0} = 4'b0000;
        model_reset();
        #1 chk("por", observed(), 7'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        repeat (2) cycle(4'b0000, "idle");

        // Single requester held: back-to-back re-grants with no gap
        for (int i = 0; i < 10; i++) cycle(4'b0100, "single2");
        for (int i = 0; i < 6; i++) cycle(4'b0000, "drain2");

        async_reset(4'b0000, "rst_idle");

        // Full contention: 0,1,2,3,0
        for (int i = 0; i < 20; i++) cycle(4'b1111, "contend");
        for (int i = 0; i < 6; i++) cycle(4'b0000, "drainall");

        // One-cycle pulse while idle
        cycle(4'b0010, "pulse1");
        for (int i = 0; i < 7; i++) cycle(4'b0000, "pulse_tail");

        // Two requesters alternating
        for (int i = 0; i < 12; i++) cycle(4'b1001, "alt03");
        for (int i = 0; i < 6; i++) cycle(4'b0000, "drain03");

        // Random traffic
        for (int i = 0; i < 60; i++) cycle(4'($urandom_range(0, 15)), "rand");
        for (int i = 0; i < 6; i++) cycle(4'b0000, "drainrand");

        // Mid-burst reset during grant3, then req0 and req3 contend
        cycle(4'b1000, "g3_c1");
        cycle(4'b1000, "g3_c2");
        async_reset(4'b1001, "rst_mid");
        for (int i = 0; i < 6; i++) cycle(4'b1001, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
